// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte-wide transmit FIFO between the processor output port and the UART
//   transmit engine. Processor write strobes push bytes; a small FSM pops one
//   byte whenever the transmitter is ready and presents it with a one-cycle
//   load pulse, then waits for the transmitter to drop ready before the next.
//
//   Optional feature macro: UART_TX_FIFO_OVF_EN
//     defined   - sticky overflow flag implemented, clr_ovf_i honoured
//     undefined - overflow_o tied to 0, clr_ovf_i ignored (drops still silent)
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   wr_en_i      push strobe (one push per high cycle)
//   wr_data_i    byte to push
//   tx_rdy_i     transmitter idle / can accept a byte
//   clr_ovf_i    clear sticky overflow
//   tx_load_o    one-cycle pulse, transmitter captures tx_data_o
//   tx_data_o    registered byte handed to the transmitter
//   full_o       count == DEPTH
//   empty_o      count == 0
//   count_o      entries stored (excludes byte already handed off)
//   overflow_o   sticky, set when a push is dropped
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    input  logic              tx_rdy_i,
    input  logic              clr_ovf_i,
    output logic              tx_load_o,
    output logic [7:0]        tx_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_load_q, tx_load_d;
    state_e            state_q, state_d;

    logic full, empty, pop, push, drop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A push into a full FIFO is still taken when the same cycle pops: the
    // popped slot is the one being written (wr_ptr == rd_ptr), and the read
    // below sees the old contents because the write lands at the clock edge.
    assign push = wr_en_i && (!full || pop);
    assign drop = wr_en_i && full && !pop;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        tx_load_d = 1'b0;
        tx_data_d = tx_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && tx_rdy_i) begin
                    pop       = 1'b1;
                    tx_load_d = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD:      state_d = ST_WAIT_BUSY;
            // Transmitter must acknowledge by dropping ready before another load.
            ST_WAIT_BUSY: if (!tx_rdy_i) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_data_q <= 8'h00;
            tx_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
        end
    end

    // Storage needs no reset: contents are only read behind count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic overflow_q, overflow_d;

    // Set wins over a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_ovf_i) overflow_d = 1'b0;
        if (drop)      overflow_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) overflow_q <= 1'b0;
        else         overflow_q <= overflow_d;
    end

    assign overflow_o = overflow_q;
`else
    logic unused_ovf;
    assign unused_ovf = clr_ovf_i | drop;
    assign overflow_o = 1'b0;
`endif

    assign tx_load_o = tx_load_q;
    assign tx_data_o = tx_data_q;
    assign full_o    = full;
    assign empty_o   = empty;
    assign count_o   = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset, wr_en, tx_rdy, clr_ovf;
    logic [7:0] wr_data;
    logic       tx_load, full, empty, overflow;
    logic [7:0] tx_data;
    logic [4:0] count;

    int checks = 0;
    int failures = 0;

`ifdef UART_TX_FIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .tx_rdy_i(tx_rdy), .clr_ovf_i(clr_ovf), .tx_load_o(tx_load),
        .tx_data_o(tx_data), .full_o(full), .empty_o(empty), .count_o(count),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    // One clock: inputs set before this call are sampled at the edge,
    // outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next load, check the byte, then complete the
    // transmitter handshake: one cycle for LOAD, drop ready, raise it again.
    task automatic get_byte(input logic [7:0] exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tx_load && n < 20);
        chk("load_seen", {31'b0, tx_load}, 32'd1);
        chk("load_data", {24'b0, tx_data}, {24'b0, exp});
        step();
        tx_rdy = 1'b0;
        step();
        tx_rdy = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_rdy = 1'b0; clr_ovf = 1'b0;
        step(); step();
        reset = 1'b0;

        // Reset state, idle 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_empty", {31'b0, empty}, 32'd1);
            chk("rst_count", {27'b0, count}, 32'd0);
            chk("rst_load", {31'b0, tx_load}, 32'd0);
            chk("rst_data", {24'b0, tx_data}, 32'h00);
            chk("rst_ovf", {31'b0, overflow}, 32'd0);
        end
        chk("rst_full", {31'b0, full}, 32'd0);

        // Single byte latency: count 0 -> 1 -> 0, load at N+2
        tx_rdy = 1'b1;
        push_byte(8'h41);
        chk("t1_count1", {27'b0, count}, 32'd1);
        chk("t1_nempty", {31'b0, empty}, 32'd0);
        chk("t1_noload", {31'b0, tx_load}, 32'd0);
        step();
        chk("t1_load", {31'b0, tx_load}, 32'd1);
        chk("t1_data", {24'b0, tx_data}, 32'h41);
        chk("t1_count0", {27'b0, count}, 32'd0);
        step();
        chk("t1_pulse1", {31'b0, tx_load}, 32'd0);
        tx_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_nosecond", {31'b0, tx_load}, 32'd0);
        end
        chk("t1_hold", {24'b0, tx_data}, 32'h41);

        // Fill to full with ready low, then overflow
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("t2_full", {31'b0, full}, 32'd1);
        chk("t2_count16", {27'b0, count}, 32'd16);
        chk("t2_load_idle", {31'b0, tx_load}, 32'd0);
        push_byte(8'hAA);
        chk("t2_ovf", {31'b0, overflow}, {31'b0, OVF_EXP});
        chk("t2_count_kept", {27'b0, count}, 32'd16);
        tx_rdy = 1'b1;
        for (int i = 0; i < 16; i++) get_byte(8'(i));
        chk("t2_drained", {31'b0, empty}, 32'd1);
        chk("t2_count0", {27'b0, count}, 32'd0);
        chk("t2_ovf_sticky", {31'b0, overflow}, {31'b0, OVF_EXP});
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t2_ovf_clr", {31'b0, overflow}, 32'd0);

        // Full FIFO, push in the same cycle as the pop is accepted
        tx_rdy = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        chk("t3_full", {31'b0, full}, 32'd1);
        tx_rdy = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hBB;
        step();
        wr_en = 1'b0;
        chk("t3_load", {31'b0, tx_load}, 32'd1);
        chk("t3_data", {24'b0, tx_data}, 32'h10);
        chk("t3_count16", {27'b0, count}, 32'd16);
        chk("t3_noovf", {31'b0, overflow}, 32'd0);
        step();
        tx_rdy = 1'b0;
        step();
        tx_rdy = 1'b1;
        for (int i = 1; i < 16; i++) get_byte(8'h10 + 8'(i));
        get_byte(8'hBB);
        chk("t3_empty", {31'b0, empty}, 32'd1);

        // Ready held high after a load: only one load until it toggles
        tx_rdy = 1'b0;
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        tx_rdy = 1'b1;
        step();
        chk("t4_load1", {31'b0, tx_load}, 32'd1);
        chk("t4_data1", {24'b0, tx_data}, 32'hC1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_noload", {31'b0, tx_load}, 32'd0);
        end
        chk("t4_count2", {27'b0, count}, 32'd2);
        tx_rdy = 1'b0;
        step();
        chk("t4_low_noload", {31'b0, tx_load}, 32'd0);
        tx_rdy = 1'b1;
        step();
        chk("t4_load2", {31'b0, tx_load}, 32'd1);
        chk("t4_data2", {24'b0, tx_data}, 32'hC2);
        step();
        tx_rdy = 1'b0;
        step();
        tx_rdy = 1'b1;
        get_byte(8'hC3);

        // Reset during LOAD with 5 bytes queued
        tx_rdy = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'hD0 + 8'(i));
        tx_rdy = 1'b1;
        step();
        chk("t5_load", {31'b0, tx_load}, 32'd1);
        chk("t5_count5", {27'b0, count}, 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_load", {31'b0, tx_load}, 32'd0);
        chk("t5_rst_count", {27'b0, count}, 32'd0);
        chk("t5_rst_empty", {31'b0, empty}, 32'd1);
        chk("t5_rst_data", {24'b0, tx_data}, 32'h00);
        push_byte(8'h55);
        chk("t5_count1", {27'b0, count}, 32'd1);
        step();
        chk("t5_load55", {31'b0, tx_load}, 32'd1);
        chk("t5_data55", {24'b0, tx_data}, 32'h55);
        chk("t5_final_empty", {31'b0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit FIFO between the processor output port and the UART transmit engine. Decoded processor write strobes push bytes; the block pops one byte whenever the transmitter reports ready, presenting it with a one-cycle load pulse. The processor can queue a burst of characters without polling TxRdy per byte. The `full`/`empty` flags feed the UART status byte in place of raw TxRdy.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two, 2..256.
- `ADDR_W`, 4: log2(DEPTH); pointer width.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset (already-synchronized system reset).
- `wr_en` in 1: decoded write strobe for the transmit data port; one push per high cycle.
- `wr_data` in 8: byte to push, qualified by `wr_en`.
- `tx_rdy` in 1: transmitter ready (high = idle, can accept a byte).
- `clr_ovf` in 1: clears the sticky `overflow` flag.
- `tx_load` out 1: one-cycle pulse; transmitter captures `tx_data` on it.
- `tx_data` out 8: registered byte handed to the transmitter.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out ADDR_W+1: entries currently stored; excludes the byte already handed off.
- `overflow` out 1: sticky; set when a push is dropped.

## Operation
- Storage is DEPTH x 8 register array with `wr_ptr`/`rd_ptr` (ADDR_W bits, natural wrap) and an ADDR_W+1-bit `count`.
- Push when `wr_en` and not `full`: write `mem[wr_ptr]`, then `wr_ptr`+1.
- Push when `full`:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the byte is dropped, the pointers are unchanged, and `overflow` is set.
- Pop state machine, 3 states:
  - IDLE: if `!empty && tx_rdy`, then `tx_data <= mem[rd_ptr]`, `rd_ptr`+1, `tx_load <= 1`, and go to LOAD. Otherwise stay in IDLE.
  - LOAD: `tx_load <= 0`; go to WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_rdy == 0`, then go to IDLE. This guarantees no second load before the transmitter has acknowledged by dropping ready.
- `count` update on simultaneous push and pop: +1 -1 = unchanged. Push only: +1. Pop only: -1.
- `full` and `empty` are combinational from `count`.
- `tx_data` holds its value between loads.
- `clr_ovf` clears `overflow`. If a drop and `clr_ovf` occur in the same cycle, set wins.
- Reset, at any point including mid-handoff:
  - Pointers, `count`, `tx_data`, `tx_load` and `overflow` go to 0.
  - State goes to IDLE; queued bytes are discarded.
  - The transmitter shares the same reset, so no byte is half-handed.
- Reset values of outputs: `tx_load=0`, `tx_data=8'h00`, `full=0`, `empty=1`, `count=0`, `overflow=0`.

## Timing
- Empty FIFO, IDLE, `tx_rdy` high, push in cycle N:
  - Entry visible (`count=1`, `empty=0`) at N+1.
  - Pop decision at N+1; `tx_load` high and `tx_data` valid during N+2.
  - `count` back to 0 at N+2.
- Back-to-back throughput: at most one load per 3 cycles, limited by the transmitter's frame time in practice.
- `tx_load` is exactly one cycle wide and never asserted outside the LOAD state.
- `tx_rdy` may remain high for any number of cycles after a load. The FSM waits in WAIT_BUSY indefinitely.
- Pushes are accepted every cycle, independent of FSM state.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined: `overflow` is implemented as described, and `clr_ovf` is honoured.
- `UART_TX_FIFO_OVF_EN` undefined:
  - No overflow register; `overflow` is tied to 0 and `clr_ovf` is ignored.
  - Pushes while full without a same-cycle pop are still dropped silently; pointers and `count` are unaffected.

## Test plan
- Reset, then idle 5 cycles: `empty=1`, `count=0`, `tx_load` never high, `tx_data=8'h00`, `overflow=0`.
- `tx_rdy=1`; push 8'h41 at cycle N; model drops `tx_rdy` 2 cycles after each load for 10 cycles:
  - `tx_load` pulses at N+2 with `tx_data=8'h41`.
  - `count` sequence is 0,1,0.
  - No second pulse while `tx_rdy` stays low.
- `tx_rdy=0`; push 16 bytes 8'h00..8'h0F:
  - `full=1`, `count=16`.
  - A 17th push 8'hAA sets `overflow=1`, and `count` stays 16.
  - Release `tx_rdy`: the bytes emerge in order 00..0F and 8'hAA never appears.
  - `clr_ovf` clears the flag.
- FIFO full, pop in progress: a push in the same cycle as the IDLE pop is accepted, `count` stays 16, `overflow` stays 0, and the byte emerges last.
- Hold `tx_rdy` high continuously after a load with 3 bytes queued: exactly one `tx_load` occurs until `tx_rdy` toggles low then high, then the next byte loads.
- Assert `reset` during LOAD with 5 bytes queued: the next cycle shows `tx_load=0`, `count=0`, `empty=1`, IDLE state; a subsequent push of 8'h55 is the next byte loaded.
